// File: rtl/sp_sram_128x32.sv
// Behavioural 128x32 single-port synchronous SRAM with BIST port mux,
// power-down modes and optional output pipeline; X-free outputs.
module sp_sram_128x32 #(
    parameter int unsigned HSEN  = 0,
    parameter int unsigned GC    = 1,
    parameter int unsigned PGMEN = 0,
    parameter int unsigned TFF   = 0
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [1:0]  PD,
    input  logic [6:0]  A,
    input  logic [31:0] D,
    input  logic        WEN,
    input  logic        CEN,
    output logic [31:0] Q,
    input  logic        test_mode,
    input  logic        bist_en,
    input  logic [6:0]  bist_addr,
    input  logic [31:0] bist_data,
    input  logic        bist_web
);

    typedef enum logic [1:0] {
        PD_NORMAL   = 2'b00,
        PD_LIGHT    = 2'b01,
        PD_DEEP     = 2'b10,
        PD_SHUTDOWN = 2'b11
    } pd_mode_e;

    logic [31:0] mem_q [128];
    logic [31:0] rd_q, rd_d;
    logic [31:0] pipe_q, pipe_d;
    pd_mode_e    pd_hist_q, pd_hist_d;
    pd_mode_e    pd_mode;

    logic        bist_sel;
    logic [6:0]  addr;
    logic [31:0] din;
    logic        we_n;
    logic        ce_n;
    logic        wake;
    logic        valid;
    logic        wr_en;
    logic        rd_en;
    logic        shutdown_clr;

    always_comb begin
        pd_mode      = pd_mode_e'(PD);
        bist_sel     = test_mode & bist_en;
        addr         = bist_sel ? bist_addr : A;
        din          = bist_sel ? bist_data : D;
        we_n         = bist_sel ? bist_web  : WEN;
        ce_n         = bist_sel ? 1'b0      : CEN;
        // First normal-mode edge after any power-down is a dead cycle.
        wake         = (pd_mode == PD_NORMAL) && (pd_hist_q != PD_NORMAL);
        valid        = !ce_n && (pd_mode == PD_NORMAL) && !wake;
        wr_en        = valid && !we_n;
        rd_en        = valid && we_n;
        shutdown_clr = (pd_mode == PD_SHUTDOWN) && (pd_hist_q != PD_SHUTDOWN);
        pd_hist_d    = pd_mode;
    end

    always_comb begin
        rd_d = rd_q;
        case (pd_mode)
            PD_DEEP, PD_SHUTDOWN: rd_d = '0;
            PD_LIGHT:             rd_d = rd_q;
            default: begin
                if (wr_en) begin
                    rd_d = (TFF != 0) ? din : rd_q;
                end else if (rd_en) begin
                    rd_d = mem_q[addr];
                end else begin
                    rd_d = (GC != 0) ? rd_q : '0;
                end
            end
        endcase
        pipe_d = pd_mode[1] ? '0 : rd_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_q      <= '0;
            pipe_q    <= '0;
            pd_hist_q <= PD_NORMAL;
        end else begin
            rd_q      <= rd_d;
            pipe_q    <= pipe_d;
            pd_hist_q <= pd_hist_d;
        end
    end

    // Array clear on reset is optional; without it a write coincident with reset is simply dropped.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            if (PGMEN != 0) begin
                for (int unsigned i = 0; i < 128; i++) begin
                    mem_q[i] <= '0;
                end
            end
        end else if (shutdown_clr) begin
            for (int unsigned i = 0; i < 128; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[addr] <= din;
        end
    end

    assign Q = (HSEN != 0) ? pipe_q : rd_q;

endmodule

// File: tb/tb_sp_sram_128x32.sv
// Directed bench: two SRAM instances with opposite parameter sets share one
// stimulus stream; each Q is checked against hand-computed values.
module tb_sp_sram_128x32;

    logic        clk = 1'b0;
    logic        rstn;
    logic [1:0]  PD;
    logic [6:0]  A;
    logic [31:0] D;
    logic        WEN;
    logic        CEN;
    logic        test_mode;
    logic        bist_en;
    logic [6:0]  bist_addr;
    logic [31:0] bist_data;
    logic        bist_web;
    logic [31:0] q1;
    logic [31:0] q2;

    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;

    always #5 clk = ~clk;

    // dut1: latency 1, Q holds when deselected, array kept over reset, no write-through
    sp_sram_128x32 #(.HSEN(0), .GC(1), .PGMEN(0), .TFF(0)) dut1 (
        .clk(clk), .rstn(rstn), .PD(PD), .A(A), .D(D), .WEN(WEN), .CEN(CEN), .Q(q1),
        .test_mode(test_mode), .bist_en(bist_en), .bist_addr(bist_addr),
        .bist_data(bist_data), .bist_web(bist_web)
    );

    // dut2: latency 2, Q cleared when deselected, array cleared by reset, write-through
    sp_sram_128x32 #(.HSEN(1), .GC(0), .PGMEN(1), .TFF(1)) dut2 (
        .clk(clk), .rstn(rstn), .PD(PD), .A(A), .D(D), .WEN(WEN), .CEN(CEN), .Q(q2),
        .test_mode(test_mode), .bist_en(bist_en), .bist_addr(bist_addr),
        .bist_data(bist_data), .bist_web(bist_web)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        CEN = 1'b1; WEN = 1'b1; test_mode = 1'b0; bist_en = 1'b0; bist_web = 1'b1;
        cyc();
    endtask

    task automatic wr(input logic [6:0] a, input logic [31:0] d);
        A = a; D = d; CEN = 1'b0; WEN = 1'b0; test_mode = 1'b0; bist_en = 1'b0;
        cyc();
    endtask

    task automatic rd(input logic [6:0] a);
        A = a; CEN = 1'b0; WEN = 1'b1; test_mode = 1'b0; bist_en = 1'b0;
        cyc();
    endtask

    task automatic bist_wr(input logic tm, input logic [6:0] a, input logic [31:0] d);
        test_mode = tm; bist_en = 1'b1; bist_web = 1'b0; bist_addr = a; bist_data = d;
        CEN = 1'b1; WEN = 1'b1; A = 7'd9;
        cyc();
    endtask

    initial begin
        rstn = 1'b0; PD = 2'b00; A = '0; D = '0; WEN = 1'b1; CEN = 1'b1;
        test_mode = 1'b0; bist_en = 1'b0; bist_addr = '0; bist_data = '0; bist_web = 1'b1;
        #1;
        chk("reset_q1", q1, 32'h0);
        chk("reset_q2", q2, 32'h0);
        @(negedge clk);
        rstn = 1'b1;

        // Basic write/read at address 5
        wr(7'd5, 32'hDEADBEEF);
        chk("wr5_q1_holds", q1, 32'h0);
        chk("wr5_q2", q2, 32'h0);
        rd(7'd5);
        chk("rd5_q1", q1, 32'hDEADBEEF);
        chk("rd5_q2_wthru", q2, 32'hDEADBEEF);
        idle();
        chk("gc1_hold_q1", q1, 32'hDEADBEEF);
        chk("rd5_q2_lat2", q2, 32'hDEADBEEF);
        idle();
        chk("gc0_clear_q2", q2, 32'h0);

        // Address boundaries, back-to-back reads
        wr(7'd0, 32'h00000001);
        wr(7'd127, 32'hFFFFFFFF);
        chk("wr127_q2", q2, 32'h00000001);
        rd(7'd0);
        chk("rd0_q1", q1, 32'h00000001);
        chk("rd0_q2", q2, 32'hFFFFFFFF);
        rd(7'd127);
        chk("rd127_q1", q1, 32'hFFFFFFFF);
        chk("rd127_q2_lat2_rd0", q2, 32'h00000001);
        idle();
        chk("rd127_q2_lat2", q2, 32'hFFFFFFFF);

        // BIST port
        wr(7'd4, 32'h11111111);
        bist_wr(1'b1, 7'd3, 32'hA5A5A5A5);
        chk("bist_wr_q1_holds", q1, 32'hFFFFFFFF);
        chk("bist_wr_q2", q2, 32'h11111111);
        rd(7'd3);
        chk("bist_rd3_q1", q1, 32'hA5A5A5A5);
        chk("bist_rd3_q2_wthru", q2, 32'hA5A5A5A5);
        bist_wr(1'b0, 7'd4, 32'h5A5A5A5A);
        rd(7'd4);
        chk("bist_ignored_q1", q1, 32'h11111111);
        chk("bist_ignored_q2_gc0", q2, 32'h0);
        idle();
        chk("bist_ignored_q2", q2, 32'h11111111);

        // Deselect behaviour
        wr(7'd6, 32'h12345678);
        rd(7'd6);
        idle();
        chk("desel_q1_gc1", q1, 32'h12345678);
        chk("desel_q2_lat2", q2, 32'h12345678);
        idle();
        chk("desel_q2_gc0", q2, 32'h0);

        // Deep sleep with write attempt, then wake cycle with ignored write
        PD = 2'b10;
        wr(7'd6, 32'hCAFEF00D);
        chk("deep_q1", q1, 32'h0);
        chk("deep_q2", q2, 32'h0);
        PD = 2'b00;
        wr(7'd6, 32'h0BADF00D);
        chk("wake_q1", q1, 32'h0);
        rd(7'd6);
        chk("wake_rd6_q1", q1, 32'h12345678);
        chk("wake_rd6_q2", q2, 32'h0);

        // Light sleep holds Q even with GC=0
        PD = 2'b01;
        rd(7'd6);
        chk("light_q2_lat2", q2, 32'h12345678);
        idle();
        chk("light_q2_hold", q2, 32'h12345678);
        chk("light_q1_hold", q1, 32'h12345678);
        PD = 2'b00;
        idle();
        idle();
        chk("light_wake_q2_gc0", q2, 32'h0);

        // Reset mid-stream with a pending write
        rd(7'd5);
        chk("pre_rst_q1", q1, 32'hDEADBEEF);
        #3;
        rstn = 1'b0;
        A = 7'd5; D = 32'h77777777; CEN = 1'b0; WEN = 1'b0;
        #1;
        chk("rst_async_q1", q1, 32'h0);
        chk("rst_async_q2", q2, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        rd(7'd5);
        chk("rst_keep_q1", q1, 32'hDEADBEEF);
        rd(7'd0);
        chk("rst_keep_rd0_q1", q1, 32'h00000001);
        chk("rst_clr_q2", q2, 32'h0);
        idle();
        chk("rst_clr_rd0_q2", q2, 32'h0);

        // Shutdown clears the array
        rd(7'd127);
        PD = 2'b11;
        idle();
        chk("shutdown_q1", q1, 32'h0);
        PD = 2'b00;
        idle();
        rd(7'd127);
        chk("shutdown_rd127_q1", q1, 32'h0);
        rd(7'd3);
        chk("shutdown_rd3_q1", q1, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
